my_uart_rx: RTL

//  UART receiver; downstream counterpart of the board UART transmitter (8 data bits, even parity, 1 stop).

---
 rtl/my_uart_pkg.sv | 20 ++
 rtl/my_uart_rx_if.sv | 14 +
 rtl/uart_os_tick_gen.sv | 21 ++
 rtl/my_uart_rx.sv | 113 +++++++++++
 4 files changed

// File: rtl/my_uart_pkg.sv
// Frame format and state encodings shared by the board UART receiver and transmitter.
package my_uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam int DATA_BITS   = 8;
  localparam bit PARITY_EVEN = 1'b1;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int calc_div(input longint clk_freq, input longint baud, input longint os);
    return int'((clk_freq + (baud * os) / 2) / (baud * os));
  endfunction

endpackage

// File: rtl/my_uart_rx_if.sv
// Received-byte output register and its valid/ready handshake toward the consumer.
interface my_uart_rx_if;
  import my_uart_pkg::*;

  logic [DATA_BITS-1:0] RX_DATA;
  logic                 RX_VALID;
  logic                 RX_READY;
  logic                 PARITY_ERR;
  logic                 FRAME_ERR;
  logic                 OVERRUN;

  modport master (output RX_DATA, RX_VALID, PARITY_ERR, FRAME_ERR, OVERRUN, input RX_READY);
  modport slave  (input RX_DATA, RX_VALID, PARITY_ERR, FRAME_ERR, OVERRUN, output RX_READY);
endinterface

// File: rtl/uart_os_tick_gen.sv
// Oversample tick divider: one-cycle TICK every DIV clocks, held at phase 0 while CLR.
module uart_os_tick_gen #(
  parameter int DIV = 68
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  output logic TICK
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST || CLR)                 cnt <= '0;
    else if (cnt == W'(DIV - 1))    cnt <= '0;
    else                            cnt <= cnt + 1'b1;
  end

  assign TICK = ~CLR & (cnt == W'(DIV - 1));
endmodule

// File: rtl/my_uart_rx.sv
// UART receiver (8 data bits, even parity, 1 stop) with oversampled line recovery
// and a held output register for the consumer.
module my_uart_rx
  import my_uart_pkg::*;
#(
  parameter int CLK_FREQ   = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         UART_RX,
  output logic         BUSY,
  my_uart_rx_if.master rx
);
  localparam int DIV = calc_div(longint'(CLK_FREQ), longint'(BAUD_RATE), longint'(OVERSAMPLE));
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam logic [SCW-1:0] SC_MID  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);

  logic                 rx_meta, rx_s;
  logic                 tick;
  state_t               state;
  logic [SCW-1:0]       sc;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  // Synchronizer resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_s    <= rx_meta;
    end
  end

  // Divider is held cleared in idle, so tick phase starts fresh on each start edge.
  uart_os_tick_gen #(.DIV(DIV)) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .CLR  (state == S_IDLE),
    .TICK (tick)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= S_IDLE;
      sc            <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      par_bit       <= 1'b0;
      rx.RX_DATA    <= '0;
      rx.RX_VALID   <= 1'b0;
      rx.PARITY_ERR <= 1'b0;
      rx.FRAME_ERR  <= 1'b0;
      rx.OVERRUN    <= 1'b0;
    end else begin
      // A commit in the same cycle overrides this release below.
      if (rx.RX_VALID && rx.RX_READY) rx.RX_VALID <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            sc    <= '0;
          end
        end
        S_START: if (tick) begin
          if (sc == SC_MID) begin
            sc      <= '0;
            bit_idx <= '0;
            state   <= rx_s ? S_IDLE : S_DATA;
          end else sc <= sc + 1'b1;
        end
        S_DATA: if (tick) begin
          if (sc == SC_LAST) begin
            sc             <= '0;
            shreg[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= S_PARITY;
          end else sc <= sc + 1'b1;
        end
        S_PARITY: if (tick) begin
          if (sc == SC_LAST) begin
            sc      <= '0;
            par_bit <= rx_s;
            state   <= S_STOP;
          end else sc <= sc + 1'b1;
        end
        S_STOP: if (tick) begin
          if (sc == SC_LAST) begin
            sc    <= '0;
            state <= S_IDLE;
            if (!rx.RX_VALID || rx.RX_READY) begin
              rx.RX_DATA    <= shreg;
              rx.PARITY_ERR <= (par_bit != ^shreg);
              rx.FRAME_ERR  <= ~rx_s;
              rx.RX_VALID   <= 1'b1;
            end else begin
              rx.OVERRUN    <= 1'b1;
            end
          end else sc <= sc + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign BUSY = RST | (state != S_IDLE);
endmodule
